testpulse_sequencer: RTL and testbench

//  Controller for the APES ASIC test-pulse stimulus. On a start command it produces a burst
//  of cfg_npulse stimulus pulses with programmable period and high width. With each pulse it

---
 rtl/apes_pkg.sv | 17 +
 rtl/tp_dac_stepper.sv | 41 ++++
 rtl/testpulse_sequencer.sv | 175 +++++++++++++++++
 tb/tb_testpulse_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/apes_pkg.sv
// Shared definitions for the APES test-pulse sequencer.
//   tp_state_e     : sequencer FSM states
//   SETTLE_CYC_DEF : default clk50 cycles from initial DAC load to first stim rise
package apes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    HIGH,
    LOW,
    DONE
  } tp_state_e;

  localparam int unsigned SETTLE_CYC_DEF = 64;

endpackage

// File: rtl/tp_dac_stepper.sv
// Calibration DAC code register with saturating step and load strobe.
// Ports:
//   clk50, rst   clock, asynchronous active-high reset
//   load_start   load start_code into the DAC register
//   load_step    add step to the DAC register, saturating at all-ones
//   start_code   code for pulse 0
//   step         unsigned increment per pulse
//   dac_code     registered DAC code
//   dac_load     1-cycle strobe, dac_code valid
module tp_dac_stepper #(
  parameter int unsigned DAC_W = 10
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             load_start,
  input  logic             load_step,
  input  logic [DAC_W-1:0] start_code,
  input  logic [DAC_W-1:0] step,
  output logic [DAC_W-1:0] dac_code,
  output logic             dac_load
);

  // One extra bit catches the carry out; a carry means clamp to all-ones.
  logic [DAC_W:0] sum;

  assign sum = {1'b0, dac_code} + {1'b0, step};

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      dac_code <= '0;
      dac_load <= 1'b0;
    end else begin
      dac_load <= load_start | load_step;
      if (load_start)
        dac_code <= start_code;
      else if (load_step)
        dac_code <= sum[DAC_W] ? '1 : sum[DAC_W-1:0];
    end
  end

endmodule

// File: rtl/testpulse_sequencer.sv
// APES ASIC test-pulse sequencer: on start, loads the calibration DAC, waits
// SETTLE_CYC cycles, then emits cfg_npulse stim pulses, stepping the DAC code
// after each pulse except the last.
// Ports:
//   clk50, rst      clock, asynchronous active-high reset
//   start, abort    burst request (ignored while busy); burst terminate (wins)
//   cfg_period      rising-to-rising pulse spacing, cycles
//   cfg_width       stim high time, cycles
//   cfg_npulse      pulses per burst
//   cfg_dac_start   DAC code for pulse 0
//   cfg_dac_step    DAC increment per pulse
//   stim_out        registered ASIC stimulus
//   dac_code        registered DAC code, dac_load strobes when it changes
//   pulse_idx       index of current/last pulse
//   busy, done      burst in progress; 1-cycle strobe on normal completion
module testpulse_sequencer
  import apes_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned NPULSE_W   = 12,
  parameter int unsigned DAC_W      = 10,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                clk50,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_width,
  input  logic [NPULSE_W-1:0] cfg_npulse,
  input  logic [DAC_W-1:0]    cfg_dac_start,
  input  logic [DAC_W-1:0]    cfg_dac_step,
  output logic                stim_out,
  output logic [DAC_W-1:0]    dac_code,
  output logic                dac_load,
  output logic [NPULSE_W-1:0] pulse_idx,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYC - 1);

  tp_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, tc_val;
  logic [NPULSE_W-1:0] idx_d;
  logic [CNT_W-1:0]    eff_width, low_len;
  logic [CNT_W-1:0]    sh_high, sh_low;
  logic [NPULSE_W-1:0] sh_npulse;
  logic [DAC_W-1:0]    sh_dac_start, sh_dac_step;
  logic                accept, cnt_tc, last_pulse, load_start, load_step;

  // Low time is derived directly rather than via eff_period, so the
  // period = max(period, width+1) rule never needs a CNT_W+1 bit adder.
  assign eff_width = (cfg_width == '0) ? ONE : cfg_width;
  assign low_len   = (cfg_period > eff_width) ? (cfg_period - eff_width) : ONE;
  assign accept    = (state_q == IDLE) && start && !abort;

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      sh_high      <= '0;
      sh_low       <= '0;
      sh_npulse    <= '0;
      sh_dac_start <= '0;
      sh_dac_step  <= '0;
    end else if (accept) begin
      sh_high      <= eff_width;
      sh_low       <= low_len;
      sh_npulse    <= cfg_npulse;
      sh_dac_start <= cfg_dac_start;
      sh_dac_step  <= cfg_dac_step;
    end
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_idx <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_idx <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = pulse_idx;
    load_start = 1'b0;
    load_step  = 1'b0;
    case (state_q)
      SETTLE:  tc_val = SETTLE_TC;
      HIGH:    tc_val = sh_high - 1'b1;
      LOW:     tc_val = sh_low - 1'b1;
      default: tc_val = '0;
    endcase
    cnt_tc     = (cnt_q == tc_val);
    last_pulse = (pulse_idx == sh_npulse - 1'b1);

    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (start && !abort)
            state_d = LOAD;
        end
        LOAD: begin
          load_start = 1'b1;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = (sh_npulse == '0) ? DONE : SETTLE;
        end
        SETTLE, HIGH: begin
          if (cnt_tc) begin
            cnt_d   = '0;
            state_d = (state_q == SETTLE) ? HIGH : LOW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOW: begin
          load_step = (cnt_q == '0) && !last_pulse;
          if (cnt_tc) begin
            cnt_d = '0;
            if (last_pulse) begin
              state_d = DONE;
            end else begin
              idx_d   = pulse_idx + 1'b1;
              state_d = HIGH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // stim follows the state it enters; busy/done follow the state being left,
  // which places busy one cycle behind LOAD and drops it together with done.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      stim_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      stim_out <= (state_d == HIGH);
      busy     <= (state_q inside {LOAD, SETTLE, HIGH, LOW}) && (state_d != IDLE);
      done     <= (state_q == DONE) && !abort;
    end
  end

  tp_dac_stepper #(
    .DAC_W(DAC_W)
  ) u_dac (
    .clk50      (clk50),
    .rst        (rst),
    .load_start (load_start),
    .load_step  (load_step),
    .start_code (sh_dac_start),
    .step       (sh_dac_step),
    .dac_code   (dac_code),
    .dac_load   (dac_load)
  );

endmodule

// File: tb/tb_testpulse_sequencer.sv
// Directed bench for testpulse_sequencer.
module tb_testpulse_sequencer;

  logic        clk50 = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_width  = '0;
  logic [11:0] cfg_npulse = '0;
  logic [9:0]  cfg_dac_start = '0;
  logic [9:0]  cfg_dac_step  = '0;
  logic        stim_out;
  logic [9:0]  dac_code;
  logic        dac_load;
  logic [11:0] pulse_idx;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int nload = 0;
  int ndone = 0;

  testpulse_sequencer #(
    .CNT_W(16),
    .NPULSE_W(12),
    .DAC_W(10),
    .SETTLE_CYC(64)
  ) dut (
    .clk50         (clk50),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_period    (cfg_period),
    .cfg_width     (cfg_width),
    .cfg_npulse    (cfg_npulse),
    .cfg_dac_start (cfg_dac_start),
    .cfg_dac_step  (cfg_dac_step),
    .stim_out      (stim_out),
    .dac_code      (dac_code),
    .dac_load      (dac_load),
    .pulse_idx     (pulse_idx),
    .busy          (busy),
    .done          (done)
  );

  always #10 clk50 = ~clk50;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
    if (dac_load) nload++;
    if (done) ndone++;
  endtask

  task automatic set_cfg(input int per, input int wid, input int np, input int ds, input int st);
    cfg_period    = 16'(per);
    cfg_width     = 16'(wid);
    cfg_npulse    = 12'(np);
    cfg_dac_start = 10'(ds);
    cfg_dac_step  = 10'(st);
  endtask

  // Start pulse at edge k, then check the state seen after edges k and k+1.
  task automatic launch(input string tag, input int d0);
    nload = 0;
    ndone = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy_k"}, 32'(busy), 0);
    tick();
    check({tag, ".busy_k1"}, 32'(busy), 1);
    check({tag, ".load_k1"}, 32'(dac_load), 1);
    check({tag, ".dac0"}, 32'(dac_code), d0);
    check({tag, ".idx0"}, 32'(pulse_idx), 0);
  endtask

  // Wait for first rise, then measure every pulse up to done.
  task automatic measure(input string tag, input int np, input int hi, input int lo,
                         input int first_wait, input int d0, input int d1, input int d2);
    int n;
    int exp_d;
    n = 0;
    while (!stim_out && n < 300) begin tick(); n++; end
    check({tag, ".settle"}, n, first_wait);
    for (int unsigned p = 0; p < np; p++) begin
      exp_d = (p == 0) ? d0 : (p == 1) ? d1 : d2;
      check($sformatf("%s.idx%0d", tag, p), 32'(pulse_idx), p);
      check($sformatf("%s.dac%0d", tag, p), 32'(dac_code), exp_d);
      n = 0;
      while (stim_out && n < 300) begin tick(); n++; end
      check($sformatf("%s.hi%0d", tag, p), n, hi);
      n = 0;
      if (p + 1 < np) begin
        while (!stim_out && n < 300) begin tick(); n++; end
        check($sformatf("%s.lo%0d", tag, p), n, lo);
      end else begin
        while (!done && n < 300) begin tick(); n++; end
        check({tag, ".lo_to_done"}, n, lo + 1);
        check({tag, ".busy_end"}, 32'(busy), 0);
        check({tag, ".stim_end"}, 32'(stim_out), 0);
      end
    end
    check({tag, ".ndone"}, ndone, 1);
    check({tag, ".nload"}, nload, np);
    tick();
    check({tag, ".done_1cyc"}, 32'(done), 0);
  endtask

  initial begin
    // Reset values
    tick();
    check("rst.outs", {20'(0), stim_out, busy, done, dac_load, 28'(0)}, 0);
    check("rst.dac", 32'(dac_code), 0);
    check("rst.idx", 32'(pulse_idx), 0);
    rst = 1'b0;
    tick();

    // 1: basic 3-pulse burst
    set_cfg(10, 4, 3, 100, 5);
    launch("t1", 100);
    measure("t1", 3, 4, 6, 64, 100, 105, 110);

    // 2: zero pulses
    set_cfg(10, 4, 0, 33, 5);
    launch("t2", 33);
    check("t2.done_k1", 32'(done), 0);
    tick();
    check("t2.done_k2", 32'(done), 1);
    check("t2.busy_k2", 32'(busy), 0);
    check("t2.stim", 32'(stim_out), 0);
    repeat (3) tick();
    check("t2.nload", nload, 1);
    check("t2.ndone", ndone, 1);

    // 3: saturation
    set_cfg(10, 4, 3, 1020, 3);
    launch("t3", 1020);
    measure("t3", 3, 4, 6, 64, 1020, 1023, 1023);

    // 4: width/period clamping
    set_cfg(0, 0, 2, 0, 1);
    launch("t4a", 0);
    measure("t4a", 2, 1, 1, 64, 0, 1, 0);
    set_cfg(5, 8, 2, 7, 2);
    launch("t4b", 7);
    measure("t4b", 2, 8, 1, 64, 7, 9, 0);

    // 5: abort during second HIGH
    set_cfg(10, 4, 5, 100, 5);
    launch("t5", 100);
    repeat (64) tick();
    check("t5.rise0", 32'(stim_out), 1);
    repeat (10) tick();
    check("t5.rise1", 32'(stim_out), 1);
    check("t5.idx1", 32'(pulse_idx), 1);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5.stim", 32'(stim_out), 0);
    check("t5.busy", 32'(busy), 0);
    check("t5.idx", 32'(pulse_idx), 1);
    check("t5.dac", 32'(dac_code), 105);
    repeat (5) tick();
    check("t5.ndone", ndone, 0);
    check("t5.idle", {31'(0), busy | stim_out}, 0);

    // start together with abort in IDLE: no burst
    nload = 0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    check("sa.busy", 32'(busy), 0);
    check("sa.nload", nload, 0);

    // 6: restart and cfg change while busy
    set_cfg(10, 4, 2, 50, 7);
    launch("t6", 50);
    set_cfg(3, 1, 1, 0, 100);
    start = 1'b1;
    tick();
    start = 1'b0;
    measure("t6", 2, 4, 6, 63, 50, 57, 0);

    // rst mid-burst
    set_cfg(10, 4, 3, 200, 9);
    launch("t7", 200);
    repeat (64) tick();
    check("t7.stim_pre", 32'(stim_out), 1);
    #3 rst = 1'b1;
    #1;
    check("t7.outs", {20'(0), stim_out, busy, done, dac_load, 28'(0)}, 0);
    check("t7.dac", 32'(dac_code), 0);
    check("t7.idx", 32'(pulse_idx), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t7.idle", {31'(0), busy | stim_out}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
